// File: rtl/msi_pkg.sv
// Shared encodings for the MSI tag RAM sequencer: line states, snoop ops,
// controller FSM states and arbitration grant owner.
package msi_pkg;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic {
    SNP_BUSRD  = 1'b0,
    SNP_BUSRDX = 1'b1
  } snp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    CMP  = 2'b10,
    WR   = 2'b11
  } fsm_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_SNP = 1'b1
  } grant_e;

endpackage

// File: rtl/tag_ram_ctrl_nxt.sv
// Combinational tag compare and MSI downgrade logic for one RAM word.
// Reserved state 11 never hits, so it behaves exactly like I.
module tag_ram_ctrl_nxt
  import msi_pkg::*;
#(
  parameter int TWIDTH = 9
) (
  input  logic [TWIDTH+1:0] dout_i,
  input  logic [TWIDTH-1:0] tag_i,
  input  logic              op_i,
  output logic              hit_o,
  output logic              flush_o,
  output logic              wr_o,
  output logic [1:0]        rd_state_o,
  output logic [TWIDTH+1:0] new_word_o
);

  logic [1:0]        curSt;
  logic [TWIDTH-1:0] curTag;
  logic [1:0]        newSt;

  assign curSt  = dout_i[1:0];
  assign curTag = dout_i[TWIDTH+1:2];

  always_comb begin
    hit_o = (curTag == tag_i) && ((curSt == ST_S) || (curSt == ST_M));
    flush_o = hit_o && (curSt == ST_M);
    rd_state_o = hit_o ? curSt : ST_I;
    newSt = curSt;
    // BusRdX invalidates any valid copy; BusRd only demotes a modified line.
    if (hit_o) begin
      if (op_i == SNP_BUSRDX) begin
        newSt = ST_I;
      end else if (curSt == ST_M) begin
        newSt = ST_S;
      end
    end
    wr_o = hit_o && (newSt != curSt);
    new_word_o = {curTag, newSt};
  end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Arbiter and read/compare/write sequencer sharing one single-port tag RAM
// between the CPU requester and the bus-snoop requester.
module tag_ram_ctrl
  import msi_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 9,
  localparam int DWIDTH = TWIDTH + 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_index,
  input  logic [TWIDTH-1:0] cpu_tag,
  input  logic [1:0]        cpu_state,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic [1:0]        cpu_rd_state,
  input  logic              snp_req,
  input  logic              snp_op,
  input  logic [AWIDTH-1:0] snp_index,
  input  logic [TWIDTH-1:0] snp_tag,
  output logic              snp_done,
  output logic              snp_hit,
  output logic              snp_flush,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              busy
);

  fsm_e              state_q, state_d;
  grant_e            owner_q, owner_d;
  grant_e            last_q, last_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [TWIDTH-1:0] tag_q, tag_d;
  logic              op_q, op_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic              cpuHit_q, cpuHit_d;
  logic [1:0]        cpuSt_q, cpuSt_d;
  logic              snpHit_q, snpHit_d;
  logic              snpFlush_q, snpFlush_d;

  logic              nxtHit, nxtFlush, nxtWr;
  logic [1:0]        nxtRdState;
  logic [DWIDTH-1:0] nxtWord;
  logic              cpuCmpDone, snpCmpDone, inWr, snpWins;

  tag_ram_ctrl_nxt #(.TWIDTH(TWIDTH)) u_nxt (
    .dout_i     (ram_dout),
    .tag_i      (tag_q),
    .op_i       (op_q),
    .hit_o      (nxtHit),
    .flush_o    (nxtFlush),
    .wr_o       (nxtWr),
    .rd_state_o (nxtRdState),
    .new_word_o (nxtWord)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= GNT_CPU;
      last_q     <= GNT_CPU;
      idx_q      <= '0;
      tag_q      <= '0;
      op_q       <= 1'b0;
      din_q      <= '0;
      cpuHit_q   <= 1'b0;
      cpuSt_q    <= ST_I;
      snpHit_q   <= 1'b0;
      snpFlush_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      op_q       <= op_d;
      din_q      <= din_d;
      cpuHit_q   <= cpuHit_d;
      cpuSt_q    <= cpuSt_d;
      snpHit_q   <= snpHit_d;
      snpFlush_q <= snpFlush_d;
    end
  end

  // Snoop normally wins a tie; CPU wins only right after a snoop grant.
  assign snpWins = snp_req && !(cpu_req && (last_q == GNT_SNP));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    op_d       = op_q;
    din_d      = din_q;
    cpuHit_d   = cpuHit_q;
    cpuSt_d    = cpuSt_q;
    snpHit_d   = snpHit_q;
    snpFlush_d = snpFlush_q;
    case (state_q)
      IDLE: begin
        if (snpWins) begin
          owner_d = GNT_SNP;
          last_d  = GNT_SNP;
          idx_d   = snp_index;
          tag_d   = snp_tag;
          op_d    = snp_op;
          state_d = RD;
        end else if (cpu_req) begin
          owner_d = GNT_CPU;
          last_d  = GNT_CPU;
          idx_d   = cpu_index;
          tag_d   = cpu_tag;
          if (cpu_wr) begin
            din_d   = {cpu_tag, cpu_state};
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CMP;
      CMP: begin
        if (owner_q == GNT_CPU) begin
          cpuHit_d = nxtHit;
          cpuSt_d  = nxtRdState;
          state_d  = IDLE;
        end else begin
          snpHit_d   = nxtHit;
          snpFlush_d = nxtFlush;
          if (nxtWr) begin
            din_d   = nxtWord;
            state_d = WR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results completing in CMP come straight from the compare; otherwise the
  // registered copy is shown so values only change on a done pulse.
  assign cpuCmpDone = !reset && (state_q == CMP) && (owner_q == GNT_CPU);
  assign snpCmpDone = !reset && (state_q == CMP) && (owner_q == GNT_SNP) && !nxtWr;
  assign inWr       = !reset && (state_q == WR);

  assign cpu_done     = cpuCmpDone || (inWr && (owner_q == GNT_CPU));
  assign snp_done     = snpCmpDone || (inWr && (owner_q == GNT_SNP));
  assign cpu_hit      = cpuCmpDone ? nxtHit : cpuHit_q;
  assign cpu_rd_state = cpuCmpDone ? nxtRdState : cpuSt_q;
  assign snp_hit      = snpCmpDone ? nxtHit : snpHit_q;
  assign snp_flush    = snpCmpDone ? nxtFlush : snpFlush_q;

  assign ram_addr = idx_q;
  assign ram_din  = din_q;
  assign ram_we   = inWr;
  assign busy     = (state_q != IDLE);

endmodule
